generador_sync: RTL and testbench

GENERADOR_SYNC -- requirements
Module: generador_sync

---
 rtl/generador_sync.sv | 106 ++++++++++
 tb/tb_generador_sync.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/generador_sync.sv
// VGA-style timing generator: divides clk by two into a pixel enable and walks
// a raster of H_TOT x V_TOT pixels, producing registered sync/blank/frame_start.
module generador_sync #(
  parameter int H_VIS = 640,
  parameter int H_FP  = 16,
  parameter int H_SP  = 96,
  parameter int H_BP  = 48,
  parameter int V_VIS = 480,
  parameter int V_FP  = 10,
  parameter int V_SP  = 2,
  parameter int V_BP  = 33
) (
  input  logic       clk,
  input  logic       reset,
  output logic       pixel_tick,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       hsync,
  output logic       vsync,
  output logic       blank,
  output logic       frame_start
);

  localparam logic [9:0] H_TOT    = 10'(H_VIS + H_FP + H_SP + H_BP);
  localparam logic [9:0] V_TOT    = 10'(V_VIS + V_FP + V_SP + V_BP);
  localparam logic [9:0] H_LAST   = 10'(H_VIS + H_FP + H_SP + H_BP - 1);
  localparam logic [9:0] V_LAST   = 10'(V_VIS + V_FP + V_SP + V_BP - 1);
  localparam logic [9:0] HS_FIRST = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_VIS + H_FP + H_SP - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_VIS + V_FP + V_SP - 1);
  localparam logic [9:0] H_VIS_W  = 10'(H_VIS);
  localparam logic [9:0] V_VIS_W  = 10'(V_VIS);

  // run_q is low only on the first edge after reset, so the tick stays 0 there
  // and the first post-reset cycle can be flagged as a frame start.
  logic       run_q,   run_d;
  logic       tick_q,  tick_d;
  logic [9:0] x_q,     x_d;
  logic [9:0] y_q,     y_d;
  logic       hs_q,    hs_d;
  logic       vs_q,    vs_d;
  logic       bl_q,    bl_d;
  logic       fs_q,    fs_d;

  always_comb begin
    run_d  = 1'b1;
    tick_d = run_q & ~tick_q;
    x_d    = x_q;
    y_d    = y_q;
    fs_d   = ~run_q;

    if (tick_q) begin
      if (x_q == H_LAST) begin
        x_d = '0;
        if (y_q == V_LAST) begin
          y_d  = '0;
          fs_d = 1'b1;
        end else begin
          y_d = y_q + 10'd1;
        end
      end else begin
        x_d = x_q + 10'd1;
      end
    end

    if (reset) begin
      run_d  = 1'b0;
      tick_d = 1'b0;
      x_d    = '0;
      y_d    = '0;
      fs_d   = 1'b0;
    end
  end

  // Decode from the next-state counters so sync/blank line up with pixel_x/y.
  always_comb begin
    hs_d = !((x_d >= HS_FIRST) && (x_d <= HS_LAST));
    vs_d = !((y_d >= VS_FIRST) && (y_d <= VS_LAST));
    bl_d = (x_d >= H_VIS_W) || (y_d >= V_VIS_W);
  end

  always_ff @(posedge clk) begin
    run_q  <= run_d;
    tick_q <= tick_d;
    x_q    <= x_d;
    y_q    <= y_d;
    hs_q   <= hs_d;
    vs_q   <= vs_d;
    bl_q   <= bl_d;
    fs_q   <= fs_d;
  end

  assign pixel_tick  = tick_q;
  assign pixel_x     = x_q;
  assign pixel_y     = y_q;
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign blank       = bl_q;
  assign frame_start = fs_q;

  // H_TOT/V_TOT kept for readability of the raster size; the wrap uses *_LAST.
  logic unused_tot;
  assign unused_tot = ^{H_TOT, V_TOT};

endmodule

// File: tb/tb_generador_sync.sv
// Bench for generador_sync: a shrunken-raster instance for whole-frame checks and a
// default-sized one for line timing, both checked every cycle against arithmetic.
module tb_generador_sync;

  localparam int SH_VIS = 16, SH_FP = 4, SH_SP = 6, SH_BP = 4;
  localparam int SV_VIS = 10, SV_FP = 2, SV_SP = 2, SV_BP = 3;
  localparam int SH_TOT = SH_VIS + SH_FP + SH_SP + SH_BP;
  localparam int SV_TOT = SV_VIS + SV_FP + SV_SP + SV_BP;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       s_tick, s_hs, s_vs, s_bl, s_fs;
  logic [9:0] s_x, s_y;
  logic       d_tick, d_hs, d_vs, d_bl, d_fs;
  logic [9:0] d_x, d_y;

  int checks = 0;
  int errors = 0;
  int t = 0;
  bit rstd = 1'b1;
  int hrun = 0, vrun = 0, last_fs = -1;

  always #5 clk = ~clk;

  generador_sync #(
    .H_VIS(SH_VIS), .H_FP(SH_FP), .H_SP(SH_SP), .H_BP(SH_BP),
    .V_VIS(SV_VIS), .V_FP(SV_FP), .V_SP(SV_SP), .V_BP(SV_BP)
  ) u_small (
    .clk(clk), .reset(reset), .pixel_tick(s_tick), .pixel_x(s_x), .pixel_y(s_y),
    .hsync(s_hs), .vsync(s_vs), .blank(s_bl), .frame_start(s_fs)
  );

  generador_sync u_dflt (
    .clk(clk), .reset(reset), .pixel_tick(d_tick), .pixel_x(d_x), .pixel_y(d_y),
    .hsync(d_hs), .vsync(d_vs), .blank(d_bl), .frame_start(d_fs)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: t clocks after reset release, the raster position is t/2 pixels in.
  task automatic check_one(input string nm, input int hvis, hfp, hsp, htot,
                           input int vvis, vfp, vsp, vtot,
                           input logic tick, fs, hs, vs, bl, input logic [9:0] x, y);
    int p, ex, ey, etick, efs, ehs, evs, ebl;
    if (rstd) begin
      ex = 0; ey = 0; etick = 0; efs = 0; ehs = 1; evs = 1; ebl = 0;
    end else begin
      p     = (t / 2) % (htot * vtot);
      ex    = p % htot;
      ey    = p / htot;
      etick = t % 2;
      efs   = ((t % (2 * htot * vtot)) == 0) ? 1 : 0;
      ehs   = (ex >= hvis + hfp && ex < hvis + hfp + hsp) ? 0 : 1;
      evs   = (ey >= vvis + vfp && ey < vvis + vfp + vsp) ? 0 : 1;
      ebl   = (ex >= hvis || ey >= vvis) ? 1 : 0;
    end
    chk({nm, "_x"}, 32'(x), 32'(ex));
    chk({nm, "_y"}, 32'(y), 32'(ey));
    chk({nm, "_tick"}, 32'(tick), 32'(etick));
    chk({nm, "_fs"}, 32'(fs), 32'(efs));
    chk({nm, "_hsync"}, 32'(hs), 32'(ehs));
    chk({nm, "_vsync"}, 32'(vs), 32'(evs));
    chk({nm, "_blank"}, 32'(bl), 32'(ebl));
  endtask

  task automatic step(input bit rst);
    reset = rst;
    @(posedge clk);
    if (rst) rstd = 1'b1;
    else begin
      t    = rstd ? 0 : t + 1;
      rstd = 1'b0;
    end
    @(negedge clk);
    check_one("s", SH_VIS, SH_FP, SH_SP, SH_TOT, SV_VIS, SV_FP, SV_SP, SV_TOT,
              s_tick, s_fs, s_hs, s_vs, s_bl, s_x, s_y);
    check_one("d", 640, 16, 96, 800, 480, 10, 2, 525,
              d_tick, d_fs, d_hs, d_vs, d_bl, d_x, d_y);
    if (rstd) begin
      hrun = 0; vrun = 0; last_fs = -1;
    end else begin
      // hsync pulse on the default raster: starts 1312 clks into a line, lasts 192.
      if (!d_hs) begin
        if (hrun == 0) chk("d_hs_start", 32'(t % 1600), 32'd1312);
        hrun++;
      end else if (hrun > 0) begin
        chk("d_hs_len", 32'(hrun), 32'd192);
        hrun = 0;
      end
      if (!s_vs) begin
        if (vrun == 0) chk("s_vs_start_y", 32'(s_y), 32'(SV_VIS + SV_FP));
        vrun++;
      end else if (vrun > 0) begin
        chk("s_vs_len", 32'(vrun), 32'(2 * SV_SP * SH_TOT));
        vrun = 0;
      end
      if (s_fs) begin
        if (last_fs >= 0) chk("s_fs_gap", 32'(t - last_fs), 32'(2 * SH_TOT * SV_TOT));
        last_fs = t;
      end
    end
  endtask

  initial begin
    int found;
    @(negedge clk);
    for (int i = 0; i < 3; i++) step(1'b1);
    chk("rst_hsync", 32'(s_hs), 32'd1);
    chk("rst_blank", 32'(d_bl), 32'd0);

    // Release: first clk has frame_start=1 and tick=0, then 1,0,1.
    step(1'b0);
    chk("rel_fs", 32'(s_fs), 32'd1);
    chk("rel_tick0", 32'(d_tick), 32'd0);
    for (int i = 0; i < 3200; i++) step(1'b0);
    chk("d_line_wrapped_y", 32'(d_y), 32'd2);

    // Reset mid hsync pulse of the small raster.
    found = 0;
    for (int i = 0; i < 2000 && found == 0; i++) begin
      step(1'b0);
      if (s_x == 10'd23 && s_y == 10'd7 && s_hs == 1'b0) found = 1;
    end
    chk("find_hs_low", 32'(found), 32'd1);
    step(1'b1);
    chk("midrst_hsync", 32'(s_hs), 32'd1);
    chk("midrst_x", 32'(s_x), 32'd0);
    chk("midrst_y", 32'(s_y), 32'd0);
    found = 0;
    for (int i = 0; i < 200 && found == 0; i++) begin
      step(1'b0);
      if (s_hs == 1'b0) found = 1;
    end
    chk("hs_after_rst_x", 32'(s_x), 32'(SH_VIS + SH_FP));

    // Randomized run lengths with randomized reset bursts.
    for (int r = 0; r < 5; r++) begin
      int len, rl;
      len = int'($urandom_range(40, 1500));
      rl  = int'($urandom_range(1, 3));
      for (int i = 0; i < len; i++) step(1'b0);
      for (int i = 0; i < rl; i++) step(1'b1);
    end
    for (int i = 0; i < 2200; i++) step(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
